// File: rtl/sd_spi_shifter.sv
// SPI mode-0 byte shift engine for the SD path: drives MOSI MSB-first, captures
// MISO on rising sclk, and gates the upstream clock divider through div_en.
module sd_spi_shifter #(
  parameter int unsigned BITS = 8
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            tx_valid,
  input  logic [BITS-1:0] tx_data,
  output logic            tx_ready,
  output logic            rx_valid,
  output logic [BITS-1:0] rx_data,
  output logic            busy,
  output logic            div_en,
  input  logic            sclk,
  input  logic            sclk_fall,
  input  logic            miso,
  output logic            mosi,
  input  logic            cs_req,
  output logic            cs_n
);

  localparam int unsigned CW = $clog2(BITS + 1);

  typedef enum logic [1:0] {IDLE, SHIFT, FINISH} state_t;

  state_t          state, state_nx;
  logic            sclk_q;
  logic [CW-1:0]   cnt, cnt_nx;
  logic [BITS-1:0] shift_tx, shift_tx_nx;
  logic [BITS-1:0] shift_rx, shift_rx_nx;
  logic [BITS-1:0] rx_data_nx;
  logic            mosi_nx, div_en_nx, rx_valid_nx;
  logic            rise, fall;

  assign rise     = sclk & ~sclk_q;
  assign fall     = sclk_fall & div_en;
  assign tx_ready = (state == IDLE);
  assign busy     = (state != IDLE);

  always_comb begin
    state_nx    = state;
    cnt_nx      = cnt;
    shift_tx_nx = shift_tx;
    shift_rx_nx = shift_rx;
    rx_data_nx  = rx_data;
    mosi_nx     = mosi;
    div_en_nx   = div_en;
    rx_valid_nx = 1'b0;
    unique case (state)
      IDLE: begin
        mosi_nx   = 1'b1;
        div_en_nx = 1'b0;
        if (tx_valid) begin
          shift_tx_nx = tx_data;
          mosi_nx     = tx_data[BITS-1];
          cnt_nx      = '0;
          div_en_nx   = 1'b1;
          state_nx    = SHIFT;
        end
      end
      SHIFT: begin
        // Rise wins over fall; a fall before the first rise is the leftover
        // edge of a divider that was parked with sclk high.
        if (rise) begin
          shift_rx_nx = (shift_rx << 1) | BITS'(miso);
          cnt_nx      = cnt + CW'(1);
          if (cnt_nx == CW'(BITS)) state_nx = FINISH;
        end else if (fall && (cnt != '0)) begin
          shift_tx_nx = shift_tx << 1;
          mosi_nx     = shift_tx_nx[BITS-1];
        end
      end
      FINISH: begin
        if (fall) begin
          div_en_nx   = 1'b0;
          mosi_nx     = 1'b1;
          rx_data_nx  = shift_rx;
          rx_valid_nx = 1'b1;
          state_nx    = IDLE;
        end
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      sclk_q   <= 1'b1;
      cnt      <= '0;
      shift_tx <= '0;
      shift_rx <= '0;
      rx_data  <= '0;
      rx_valid <= 1'b0;
      mosi     <= 1'b1;
      div_en   <= 1'b0;
      cs_n     <= 1'b1;
    end else begin
      state    <= state_nx;
      sclk_q   <= sclk;
      cnt      <= cnt_nx;
      shift_tx <= shift_tx_nx;
      shift_rx <= shift_rx_nx;
      rx_data  <= rx_data_nx;
      rx_valid <= rx_valid_nx;
      mosi     <= mosi_nx;
      div_en   <= div_en_nx;
      cs_n     <= ~cs_req;
    end
  end

endmodule

// File: tb/tb_sd_spi_shifter.sv
// Scoreboard bench for sd_spi_shifter with a behavioural clock divider and SD card model.
module tb_sd_spi_shifter;

  localparam int unsigned BITS = 8;

  logic            clk = 1'b0;
  logic            rst = 1'b1;
  logic            tx_valid = 1'b0;
  logic [BITS-1:0] tx_data = '0;
  logic            tx_ready, rx_valid, busy, div_en, mosi, cs_n;
  logic [BITS-1:0] rx_data;
  logic            sclk, sclk_fall;
  logic            miso = 1'b0;
  logic            cs_req = 1'b0;

  always #5 clk = ~clk;

  sd_spi_shifter #(.BITS(BITS)) dut (
    .clk(clk), .rst(rst), .tx_valid(tx_valid), .tx_data(tx_data),
    .tx_ready(tx_ready), .rx_valid(rx_valid), .rx_data(rx_data), .busy(busy),
    .div_en(div_en), .sclk(sclk), .sclk_fall(sclk_fall), .miso(miso),
    .mosi(mosi), .cs_req(cs_req), .cs_n(cs_n)
  );

  // Divider: toggles sclk every V+1 enabled cycles, strobes on the high->low toggle.
  int unsigned V = 1;
  int unsigned dcnt;
  always @(posedge clk) begin
    if (rst) begin
      sclk <= 1'b1; sclk_fall <= 1'b0; dcnt <= 0;
    end else begin
      sclk_fall <= 1'b0;
      if (div_en) begin
        if (dcnt >= V) begin
          dcnt <= 0; sclk <= ~sclk; sclk_fall <= sclk;
        end else dcnt <= dcnt + 1;
      end else dcnt <= 0;
    end
  end

  typedef struct {logic [BITS-1:0] tx; logic [BITS-1:0] rx;} exp_t;
  exp_t sb[$];

  int checks = 0, failures = 0;
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  logic            exp_cs = 1'b1;
  logic [BITS-1:0] cur_pat = '0;
  bit              echo = 0;
  logic            sclk_prev = 1'b1;
  logic            prev_rxv = 1'b0;
  logic [BITS-1:0] mosi_word = '0;
  int unsigned     rise_cnt = 0, rxv_count = 0;
  time             last_rxv_time = 0, accept_time = 0;

  always @(posedge clk) exp_cs <= rst ? 1'b1 : ~cs_req;

  initial forever begin
    @(negedge clk);
    if ($urandom_range(0, 3) == 0) cs_req = ~cs_req;
  end

  // Monitor: card model, rise bookkeeping and scoreboard pops.
  always @(negedge clk) begin : monitor
    exp_t e;
    logic rise_b, fall_b;
    check("cs_n", 32'(cs_n), 32'(exp_cs));
    if (rst) begin
      rise_cnt = 0; mosi_word = '0;
    end else begin
      rise_b = sclk && !sclk_prev && div_en;
      fall_b = sclk_fall && div_en;
      if (fall_b) check("edge_overlap", 32'(rise_b), 32'(0));
      if (prev_rxv) check("rx_valid_pulse", 32'(rx_valid), 32'(0));
      if (rise_b) begin
        mosi_word = (mosi_word << 1) | BITS'(mosi);
        if (echo) miso = mosi;
        else if (rise_cnt < BITS) miso = cur_pat[BITS-1-rise_cnt];
        rise_cnt++;
      end
      if (rx_valid) begin
        rxv_count++;
        last_rxv_time = $time;
        if (sb.size() == 0) begin
          checks++; failures++;
          $display("FAIL unexpected_rx_valid: got rx_data %0h expected no pulse at %0t", rx_data, $time);
        end else begin
          e = sb.pop_front();
          check("rx_data", 32'(rx_data), 32'(e.rx));
          check("mosi_bits", 32'(mosi_word), 32'(e.tx));
          check("rise_count", rise_cnt, BITS);
          check("div_en_done", 32'(div_en), 32'(0));
          check("mosi_idle", 32'(mosi), 32'(1));
          if (V > 0) check("sclk_parked", 32'(sclk), 32'(0));
        end
      end
      if (tx_valid && tx_ready) begin
        rise_cnt = 0; mosi_word = '0;
      end
    end
    prev_rxv = rx_valid && !rst;
    sclk_prev = sclk;
  end

  task automatic send(input logic [BITS-1:0] d, input logic [BITS-1:0] pat,
                      input bit ech, input bit keep);
    int unsigned n = 0;
    exp_t e;
    tx_data = d; tx_valid = 1'b1; cur_pat = pat; echo = ech;
    forever begin
      @(negedge clk);
      if (tx_ready) break;
      n++;
      if (n > 5000) begin
        checks++; failures++;
        $display("FAIL accept_timeout: got tx_ready 0 expected 1 at %0t", $time);
        tx_valid = 1'b0;
        return;
      end
    end
    accept_time = $time;
    e.tx = d; e.rx = ech ? d : pat;
    sb.push_back(e);
    @(posedge clk); #1;
    if (!keep) tx_valid = 1'b0;
  endtask

  task automatic wait_idle();
    for (int i = 0; i < 5000; i++) begin
      @(posedge clk); #1;
      if (sb.size() == 0 && !busy) return;
    end
    checks++; failures++;
    $display("FAIL idle_timeout: got busy %0b pending %0d expected idle at %0t", busy, sb.size(), $time);
  endtask

  initial begin : watchdog
    #3_000_000;
    $display("FAIL global_timeout: got running expected finished at %0t", $time);
    $fatal(1, "timeout");
  end

  initial begin : stim
    int unsigned rx_before;
    exp_t dropped;
    repeat (3) @(posedge clk);
    #1;
    check("rst_tx_ready", 32'(tx_ready), 32'(1));
    check("rst_busy", 32'(busy), 32'(0));
    check("rst_div_en", 32'(div_en), 32'(0));
    check("rst_rx_valid", 32'(rx_valid), 32'(0));
    check("rst_rx_data", 32'(rx_data), 32'(0));
    check("rst_mosi", 32'(mosi), 32'(1));
    check("rst_cs_n", 32'(cs_n), 32'(1));
    rst = 1'b0;
    repeat (2) @(posedge clk);
    #1;

    // First transfer after reset: sclk starts high.
    V = 1;
    send(8'hA5, 8'h3C, 0, 0);
    wait_idle();

    // Back-to-back with tx_valid held.
    send(8'hFF, 8'hFF, 0, 1);
    send(8'h00, 8'hFF, 0, 0);
    check("b2b_accept_on_rx_valid", 32'(accept_time == last_rxv_time), 32'(1));
    check("b2b_busy_after_accept", 32'(busy), 32'(1));
    wait_idle();

    // Fastest divider with MISO echoing MOSI.
    V = 0;
    send(8'h81, 8'h00, 1, 0);
    wait_idle();

    // Reset after the 4th rise, then a clean repeat.
    V = 1;
    send(8'h55, 8'h9A, 0, 0);
    for (int i = 0; i < 5000; i++) begin
      @(posedge clk);
      if (rise_cnt == 4) break;
    end
    check("reached_4th_rise", rise_cnt, 4);
    #1 rst = 1'b1;
    @(posedge clk); #1;
    check("mid_rst_busy", 32'(busy), 32'(0));
    check("mid_rst_div_en", 32'(div_en), 32'(0));
    check("mid_rst_mosi", 32'(mosi), 32'(1));
    check("mid_rst_cs_n", 32'(cs_n), 32'(1));
    check("mid_rst_rx_valid", 32'(rx_valid), 32'(0));
    if (sb.size() > 0) dropped = sb.pop_back();
    rst = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    send(8'h55, 8'h9A, 0, 0);
    wait_idle();

    // tx_valid while busy must be ignored.
    rx_before = rxv_count;
    send(8'hC3, 8'h5E, 0, 0);
    repeat (5) @(posedge clk);
    #1 tx_data = 8'h12; tx_valid = 1'b1;
    @(posedge clk); #1 tx_valid = 1'b0;
    wait_idle();
    repeat (30) @(posedge clk);
    #1;
    check("busy_ignore_rx_count", rxv_count - rx_before, 1);

    // Randomised transfers over several divider settings.
    for (int t = 0; t < 8; t++) begin
      V = $urandom_range(0, 3);
      send(BITS'($urandom), BITS'($urandom), bit'($urandom_range(0, 1)), 0);
      wait_idle();
    end

    repeat (10) @(posedge clk);
    #1;
    check("scoreboard_drained", sb.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
